// File: rtl/threshold_stream_ctrl_pkg.sv
// Shared types and reset defaults for the double-threshold stream controller.
package threshold_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        STR_NONE   = 2'b00,
        STR_WEAK   = 2'b01,
        STR_STRONG = 2'b10
    } strength_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int DEF_HIGH_TH = 40;
    localparam int DEF_LOW_TH  = 20;

endpackage

// File: rtl/threshold_stream_ctrl_classify.sv
// Combinational double-threshold classifier; equality with either threshold is weak.
module thresh_classify
    import threshold_stream_ctrl_pkg::*;
#(
    parameter int MAG_W = 11
) (
    input  logic [MAG_W-1:0] i_mag,
    input  logic [MAG_W-1:0] i_high,
    input  logic [MAG_W-1:0] i_low,
    output logic [1:0]       o_strength
);

    always_comb begin
        o_strength = STR_WEAK;
        if (i_mag > i_high) begin
            o_strength = STR_STRONG;
        end else if (i_mag < i_low) begin
            o_strength = STR_NONE;
        end
    end

endmodule

// File: rtl/threshold_stream_ctrl.sv
// Frame sequencer for the double-threshold stage: config shadowing, raster markers,
// one-deep output register and saturating per-frame strong/weak counters.
module threshold_stream_ctrl
    import threshold_stream_ctrl_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int MAG_W = 11,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MAG_W-1:0] cfg_high,
    input  logic [MAG_W-1:0] cfg_low,
    input  logic             cfg_wr,
    output logic             cfg_err,
    input  logic             start,
    input  logic [MAG_W-1:0] s_mag,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [1:0]       m_strength,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_eof,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] strong_count,
    output logic [CNT_W-1:0] weak_count
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [MAG_W-1:0] RST_HIGH = MAG_W'(DEF_HIGH_TH);
    localparam logic [MAG_W-1:0] RST_LOW  = MAG_W'(DEF_LOW_TH);

    state_t           r_state;
    state_t           w_nextState;
    logic [MAG_W-1:0] r_shadowHigh;
    logic [MAG_W-1:0] r_shadowLow;
    logic [MAG_W-1:0] r_activeHigh;
    logic [MAG_W-1:0] r_activeLow;
    logic             r_cfgErr;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [CNT_W-1:0] r_strongCnt;
    logic [CNT_W-1:0] r_weakCnt;
    logic [1:0]       r_mStrength;
    logic             r_mSof;
    logic             r_mEol;
    logic             r_mEof;
    logic             r_mValid;

    logic             w_sReady;
    logic             w_busy;
    logic             w_frameDone;
    logic             w_startAcc;
    logic             w_inHs;
    logic             w_outHs;
    logic             w_cfgOk;
    logic             w_sof;
    logic             w_eol;
    logic             w_eof;
    logic [1:0]       w_strength;

    assign w_cfgOk    = (cfg_low <= cfg_high);
    assign w_startAcc = start && (r_state == ST_IDLE);
    assign w_inHs     = s_valid && w_sReady;
    assign w_outHs    = r_mValid && m_ready;
    assign w_sof      = (r_col == '0) && (r_row == '0);
    assign w_eol      = (r_col == COL_LAST);
    assign w_eof      = w_eol && (r_row == ROW_LAST);

    thresh_classify #(
        .MAG_W(MAG_W)
    ) u_classify (
        .i_mag      (s_mag),
        .i_high     (r_activeHigh),
        .i_low      (r_activeLow),
        .o_strength (w_strength)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_sReady    = 1'b0;
        w_busy      = 1'b0;
        w_frameDone = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy   = 1'b1;
                w_sReady = !r_mValid || m_ready;
                if (s_valid && w_sReady && w_eof) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (r_mValid && m_ready) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_frameDone = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // A write coinciding with an accepted start goes straight through to the active pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadowHigh <= RST_HIGH;
            r_shadowLow  <= RST_LOW;
            r_activeHigh <= RST_HIGH;
            r_activeLow  <= RST_LOW;
            r_cfgErr     <= 1'b0;
        end else begin
            r_cfgErr <= cfg_wr && !w_cfgOk;
            if (cfg_wr && w_cfgOk) begin
                r_shadowHigh <= cfg_high;
                r_shadowLow  <= cfg_low;
            end
            if (w_startAcc) begin
                r_activeHigh <= (cfg_wr && w_cfgOk) ? cfg_high : r_shadowHigh;
                r_activeLow  <= (cfg_wr && w_cfgOk) ? cfg_low  : r_shadowLow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_strongCnt <= '0;
            r_weakCnt   <= '0;
        end else if (w_startAcc) begin
            r_col       <= '0;
            r_row       <= '0;
            r_strongCnt <= '0;
            r_weakCnt   <= '0;
        end else if (w_inHs) begin
            if (w_eol) begin
                r_col <= '0;
                r_row <= w_eof ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
            if ((w_strength == STR_STRONG) && (r_strongCnt != CNT_MAX)) begin
                r_strongCnt <= r_strongCnt + CNT_W'(1);
            end
            if ((w_strength == STR_WEAK) && (r_weakCnt != CNT_MAX)) begin
                r_weakCnt <= r_weakCnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mValid    <= 1'b0;
            r_mStrength <= 2'b00;
            r_mSof      <= 1'b0;
            r_mEol      <= 1'b0;
            r_mEof      <= 1'b0;
        end else if (w_inHs) begin
            r_mValid    <= 1'b1;
            r_mStrength <= w_strength;
            r_mSof      <= w_sof;
            r_mEol      <= w_eol;
            r_mEof      <= w_eof;
        end else if (w_outHs) begin
            r_mValid <= 1'b0;
        end
    end

    assign cfg_err      = r_cfgErr;
    assign s_ready      = w_sReady;
    assign m_strength   = r_mStrength;
    assign m_sof        = r_mSof;
    assign m_eol        = r_mEol;
    assign m_eof        = r_mEof;
    assign m_valid      = r_mValid;
    assign busy         = w_busy;
    assign frame_done   = w_frameDone;
    assign strong_count = r_strongCnt;
    assign weak_count   = r_weakCnt;

endmodule

// File: tb/tb_threshold_stream_ctrl.sv
// Scoreboard bench for threshold_stream_ctrl on a reduced 4x2 raster with 3-bit counters.
module tb_threshold_stream_ctrl;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int MW   = 11;
    localparam int CW   = 3;
    localparam int NPIX = W * H;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [MW-1:0] cfg_high;
    logic [MW-1:0] cfg_low;
    logic          cfg_wr;
    logic          cfg_err;
    logic          start;
    logic [MW-1:0] s_mag;
    logic          s_valid;
    logic          s_ready;
    logic [1:0]    m_strength;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic          m_valid;
    logic          m_ready;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] strong_count;
    logic [CW-1:0] weak_count;

    threshold_stream_ctrl #(
        .IMG_W(W),
        .IMG_H(H),
        .MAG_W(MW),
        .CNT_W(CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_high     (cfg_high),
        .cfg_low      (cfg_low),
        .cfg_wr       (cfg_wr),
        .cfg_err      (cfg_err),
        .start        (start),
        .s_mag        (s_mag),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_strength   (m_strength),
        .m_sof        (m_sof),
        .m_eol        (m_eol),
        .m_eof        (m_eof),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .strong_count (strong_count),
        .weak_count   (weak_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] str;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t          expQ[$];
    int            passCount = 0;
    int            checkCount = 0;
    logic [MW-1:0] sHigh, sLow, mHigh, mLow;
    int            pixIdx = 0;
    int            expStrong = 0;
    int            expWeak = 0;
    int            doneCount = 0;
    int            framesExpected = 0;
    int            lastFrameCycles = 0;
    bit            randReady = 1'b0;
    logic [MW-1:0] frameMags [NPIX];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [1:0] modelClass(input logic [MW-1:0] mag);
        if (mag > mHigh) return 2'b10;
        if (mag < mLow) return 2'b00;
        return 2'b01;
    endfunction

    // Output side: pop and compare on each output handshake, push on each input handshake.
    initial begin
        exp_t got;
        exp_t e;
        exp_t heldData;
        bit   haveHeld;
        haveHeld = 1'b0;
        heldData = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                haveHeld = 1'b0;
            end else begin
                if (frame_done) doneCount++;
                got = {m_strength, m_sof, m_eol, m_eof};
                if (haveHeld) checkOutput("stallStable", 32'(got), 32'(heldData));
                if (m_valid && m_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedOutput", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("strength", 32'(m_strength), 32'(e.str));
                        checkOutput("markers", 32'({m_sof, m_eol, m_eof}), 32'({e.sof, e.eol, e.eof}));
                    end
                end
                haveHeld = m_valid && !m_ready;
                heldData = got;
                if (s_valid && s_ready) begin
                    e.str = modelClass(s_mag);
                    e.sof = (pixIdx == 0);
                    e.eol = ((pixIdx % W) == W - 1);
                    e.eof = (pixIdx == NPIX - 1);
                    expQ.push_back(e);
                    if (e.str == 2'b10 && expStrong < CMAX) expStrong++;
                    if (e.str == 2'b01 && expWeak < CMAX) expWeak++;
                    pixIdx++;
                end
            end
        end
    end

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic startModel();
        mHigh = sHigh;
        mLow = sLow;
        expStrong = 0;
        expWeak = 0;
        pixIdx = 0;
        framesExpected++;
    endtask

    task automatic startFrame();
        start = 1'b1;
        startModel();
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busyAfterStart", 32'(busy), 1);
    endtask

    task automatic writeCfg(input logic [MW-1:0] h, input logic [MW-1:0] l, input bit doStart);
        cfg_high = h;
        cfg_low = l;
        cfg_wr = 1'b1;
        start = doStart;
        if (l <= h) begin
            sHigh = h;
            sLow = l;
        end
        if (doStart) startModel();
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
        start = 1'b0;
        checkOutput("cfgErrPulse", 32'(cfg_err), 32'(l > h));
        @(posedge clk);
        #1;
        checkOutput("cfgErrOneCycle", 32'(cfg_err), 0);
    endtask

    task automatic applyStimulus(input int first, input int last);
        int tmo;
        for (int i = first; i <= last; i++) begin
            s_mag = frameMags[i];
            s_valid = 1'b1;
            tmo = 0;
            forever begin
                @(negedge clk);
                lastFrameCycles++;
                if (s_ready) break;
                tmo++;
                if (tmo > 200) begin
                    checkOutput("handshakeTimeout", 0, 1);
                    s_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic waitDone();
        int tmo;
        tmo = 0;
        while (doneCount < framesExpected && tmo < 500) begin
            @(posedge clk);
            tmo++;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("frameDoneCount", 32'(doneCount), 32'(framesExpected));
        checkOutput("busyAfterDone", 32'(busy), 0);
        checkOutput("strongCount", 32'(strong_count), 32'(expStrong));
        checkOutput("weakCount", 32'(weak_count), 32'(expWeak));
        checkOutput("queueEmpty", 32'(expQ.size()), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sReady"}, 32'(s_ready), 0);
        checkOutput({tag, "_mValid"}, 32'(m_valid), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_frameDone"}, 32'(frame_done), 0);
        checkOutput({tag, "_cfgErr"}, 32'(cfg_err), 0);
        checkOutput({tag, "_counts"}, 32'({strong_count, weak_count}), 0);
        checkOutput({tag, "_data"}, 32'({m_strength, m_sof, m_eol, m_eof}), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_high = '0;
        cfg_low = '0;
        cfg_wr = 1'b0;
        start = 1'b0;
        s_mag = '0;
        s_valid = 1'b0;
        sHigh = 11'd40;
        sLow = 11'd20;
        mHigh = sHigh;
        mLow = sLow;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Default thresholds, continuous stream
        frameMags = '{11'd10, 11'd20, 11'd40, 11'd41, 11'd0, 11'd50, 11'd30, 11'd19};
        startFrame();
        lastFrameCycles = 0;
        applyStimulus(0, NPIX - 1);
        checkOutput("throughput", 32'(lastFrameCycles), NPIX);
        waitDone();
        checkOutput("frame1Strong", 32'(strong_count), 2);
        checkOutput("frame1Weak", 32'(weak_count), 3);

        // Config write mid-frame only takes effect at the next start
        frameMags = '{11'd41, 11'd45, 11'd25, 11'd19, 11'd100, 11'd60, 11'd40, 11'd20};
        startFrame();
        applyStimulus(0, 1);
        writeCfg(11'd100, 11'd50, 1'b0);
        applyStimulus(2, NPIX - 1);
        waitDone();
        frameMags = '{11'd60, 11'd101, 11'd50, 11'd49, 11'd100, 11'd0, 11'd2047, 11'd75};
        startFrame();
        applyStimulus(0, NPIX - 1);
        waitDone();

        // Rejected config keeps 100/50
        writeCfg(11'd30, 11'd80, 1'b0);
        startFrame();
        applyStimulus(0, NPIX - 1);
        waitDone();

        // Write-through when cfg_wr and start coincide
        frameMags = '{11'd25, 11'd30, 11'd60, 11'd61, 11'd29, 11'd45, 11'd90, 11'd10};
        writeCfg(11'd60, 11'd30, 1'b1);
        applyStimulus(0, NPIX - 1);
        waitDone();

        // Start while busy must not reload thresholds or restart the raster
        frameMags = '{11'd50, 11'd25, 11'd35, 11'd45, 11'd25, 11'd31, 11'd70, 11'd20};
        startFrame();
        applyStimulus(0, 2);
        writeCfg(11'd40, 11'd20, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busyAfterIgnoredStart", 32'(busy), 1);
        applyStimulus(3, NPIX - 1);
        waitDone();

        // Random downstream backpressure
        randReady = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NPIX; i++) frameMags[i] = 11'($urandom_range(0, 120));
            startFrame();
            applyStimulus(0, NPIX - 1);
            waitDone();
        end
        randReady = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-frame discards everything
        for (int i = 0; i < NPIX; i++) frameMags[i] = 11'($urandom_range(0, 120));
        startFrame();
        applyStimulus(0, 4);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midReset");
        expQ.delete();
        framesExpected--;
        sHigh = 11'd40;
        sLow = 11'd20;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("noDoneAfterReset", 32'(doneCount), 32'(framesExpected));
        frameMags = '{11'd45, 11'd10, 11'd20, 11'd40, 11'd41, 11'd39, 11'd19, 11'd100};
        startFrame();
        applyStimulus(0, NPIX - 1);
        waitDone();

        // Strong counter saturation
        for (int i = 0; i < NPIX; i++) frameMags[i] = 11'd2047;
        startFrame();
        applyStimulus(0, NPIX - 1);
        waitDone();
        checkOutput("satStrong", 32'(strong_count), CMAX);
        checkOutput("satWeak", 32'(weak_count), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/threshold_stream_ctrl.md
Name: threshold_stream_ctrl

Overview:
Frame-level controller for the double-threshold stage of the edge pipeline. It accepts a raster stream of gradient magnitudes with a valid/ready handshake and classifies each pixel against programmable high/low thresholds. Each output carries a 2-bit strength code plus start-of-frame, end-of-line and end-of-frame markers, and the block counts strong and weak pixels per frame. It sits between the gradient-magnitude stage and hysteresis edge tracking, and owns frame sequencing and threshold configuration.

Parameters:
IMG_W, 640, pixels per line
IMG_H, 480, lines per frame
MAG_W, 11, magnitude width
CNT_W, 20, width of per-frame strong/weak counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_high  in  MAG_W  requested high threshold
cfg_low  in  MAG_W  requested low threshold
cfg_wr  in  1  one-cycle strobe; writes cfg_high/cfg_low into the shadow registers
cfg_err  out  1  one-cycle pulse, cfg_wr rejected
start  in  1  one-cycle strobe; begins a frame
s_mag  in  MAG_W  input magnitude
s_valid  in  1  input valid
s_ready  out  1  input ready
m_strength  out  2  00 none, 01 weak, 10 strong; 11 never driven
m_sof  out  1  first pixel of frame
m_eol  out  1  last pixel of line
m_eof  out  1  last pixel of frame
m_valid  out  1  output valid
m_ready  in  1  downstream ready
busy  out  1  high from start accepted until frame_done
frame_done  out  1  one-cycle pulse after last output accepted
strong_count  out  CNT_W  strong pixels in the last/current frame
weak_count  out  CNT_W  weak pixels in the last/current frame

Behaviour:
- Reset values:
  - FSM in IDLE; all outputs 0.
  - Shadow and active thresholds reset to high=40, low=20.
  - Column/row counters and count registers reset to 0.
- Classification uses the active thresholds, unsigned:
  - mag > high -> 10
  - mag < low -> 00
  - otherwise -> 01
  - Equality with either threshold gives weak.
- Configuration:
  - cfg_wr with cfg_low > cfg_high: shadow unchanged; cfg_err pulses the next cycle.
  - Otherwise the shadow registers update the next cycle.
  - Shadow copies to active only when start is accepted in IDLE, so thresholds are constant within a frame.
  - cfg_wr and start in the same cycle: the start uses the new values (write-through to active).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: s_ready=0. On start: load active thresholds, clear col/row and both counts, busy=1, go to RUN.
  - RUN: s_ready = !m_valid || m_ready.
    - Handshake s_valid&&s_ready registers strength and markers into the output register, so latency is 1 cycle.
    - On handshake, col increments and wraps at IMG_W-1, at which point row increments.
    - sof is set when col=0 and row=0.
    - eol is set when col=IMG_W-1.
    - eof is set when eol is set and row=IMG_H-1; on the eof handshake go to DRAIN.
  - DRAIN: s_ready=0. Hold the output until m_valid&&m_ready, then go to DONE.
  - DONE: frame_done=1 for one cycle, busy=0, go to IDLE.
- Output register:
  - m_valid rises on an input handshake and falls on an output handshake with no new input.
  - Output data is stable while m_valid && !m_ready.
  - Simultaneous input and output handshakes give back-to-back throughput of 1 pixel/clock.
- Counters:
  - strong_count/weak_count increment on the input handshake for codes 10/01.
  - They saturate at 2^CNT_W-1.
  - They are held after frame_done until the next start.
- start while busy is ignored with no side effect.
- m_ready=0 indefinitely stalls the stream; no data is lost or duplicated.
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is discarded, with no frame_done and no eof.

Decomposition:
- Shared definitions package:
  - Strength enum type (STR_NONE=2'b00, STR_WEAK=2'b01, STR_STRONG=2'b10).
  - FSM state enum.
  - Constants DEF_HIGH_TH=40 and DEF_LOW_TH=20.
- Sub-module thresh_classify: combinational, with inputs mag/high/low and a strength output, instantiated once.
- The controller holds the FSM, counters, config shadow and output register.

Test Plan:
- Reset, then cfg unwritten, IMG_W=4, IMG_H=2, start, stream mags 10,20,40,41,0,50,30,19 with m_ready=1:
  - Output codes are 00,01,01,10,00,10,01,00.
  - sof is on pixel 0; eol is on pixels 3 and 7; eof is on pixel 7.
  - strong=2, weak=3; frame_done pulses once.
- cfg_wr high=100, low=50 during RUN:
  - The current frame still uses 40/20.
  - The next start classifies mag 60 as 01 and 101 as 10.
- cfg_wr with low=80, high=30:
  - cfg_err pulses for 1 cycle.
  - The thresholds stay unchanged; verify the next frame is classified with the prior values.
- Random m_ready toggling (50%) over a full 640x480 frame:
  - Output count is exactly 307200.
  - Order matches the input, and data stays stable while stalled.
  - Throughput is 1/clk when m_ready=1.
- start pulsed mid-RUN: ignored, with counters and markers continuous. rst_n asserted at pixel 100:
  - All outputs are 0 asynchronously.
  - A new start produces sof on the first pixel and full correct counts.
- Frame of all mag=2047 with CNT_W=4, IMG_W=8, IMG_H=4: strong_count saturates at 15 and weak_count=0.
